alu_muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer that drives the shared 32-bit ALU
//  (ADD/SUB codes) one step per cycle to provide MULU, MULHU, DIVU, REMU.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv_seq_if.sv | 23 ++
 rtl/alu_muldiv_seq.sv | 142 ++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode and mul/div operation types for the execute stage.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_NOP = 4'h0,
        ALU_ADD = 4'h1,
        ALU_SUB = 4'h2,
        ALU_AND = 4'h3,
        ALU_OR  = 4'h4,
        ALU_XOR = 4'h5,
        ALU_SLL = 4'h6,
        ALU_SRL = 4'h7,
        ALU_SRA = 4'h8,
        ALU_ROR = 4'h9,
        ALU_ROL = 4'hA
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_MULU  = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } muldiv_op_t;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response valid-ready bundle between the execute stage and the mul/div sequencer.
interface alu_muldiv_seq_if;

    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_op;
    logic [alu_pkg::XLEN-1:0]  req_a;
    logic [alu_pkg::XLEN-1:0]  req_b;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [alu_pkg::XLEN-1:0]  resp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative MULU/MULHU/DIVU/REMU sequencer borrowing the shared ALU for one
// add or subtract per cycle; one result bit per step over STEPS cycles.
module alu_muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_muldiv_seq_if.slave  bus,
    output logic [3:0]       alu_op,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    input  logic [XLEN-1:0]  alu_result
);
    import alu_pkg::*;

    localparam int unsigned CW = $clog2(STEPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    muldiv_op_t       op;
    muldiv_op_t       req_op_t;
    logic [CW-1:0]    cnt;
    // acc holds hi (multiply) or rem (divide); sh holds lo or quo
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  sh;
    logic [XLEN-1:0]  opnd;

    logic             is_mul;
    logic             req_mul;
    logic             req_div0;
    logic             last;
    logic [XLEN-1:0]  rs;
    logic             ge;
    logic             carry;
    logic             c;
    logic [XLEN-1:0]  sum;

    assign req_op_t = muldiv_op_t'(bus.req_op);
    assign req_mul  = (req_op_t == MD_MULU) || (req_op_t == MD_MULHU);
    assign req_div0 = !req_mul && (bus.req_b == '0);
    assign is_mul   = (op == MD_MULU) || (op == MD_MULHU);
    assign last     = (cnt == CW'(STEPS - 1));

    always_comb begin
        state_n        = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        alu_op         = ALU_NOP;
        alu_a          = '0;
        alu_b          = '0;
        rs             = {acc[XLEN-2:0], sh[XLEN-1]};
        ge             = acc[XLEN-1] | (rs >= opnd);
        carry          = (alu_result < acc);
        c              = 1'b0;
        sum            = acc;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_n = req_div0 ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (is_mul) begin
                    alu_op = ALU_ADD;
                    alu_a  = acc;
                    alu_b  = opnd;
                    if (sh[0]) begin
                        c   = carry;
                        sum = alu_result;
                    end
                end else begin
                    alu_op = ALU_SUB;
                    alu_a  = rs;
                    alu_b  = opnd;
                end
                if (last)
                    state_n = S_DONE;
            end
            S_DONE: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = ((op == MD_MULHU) || (op == MD_REMU)) ? acc : sh;
                if (bus.resp_ready)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op    <= MD_MULU;
            cnt   <= '0;
            acc   <= '0;
            sh    <= '0;
            opnd  <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op  <= req_op_t;
                        cnt <= '0;
                        if (req_mul) begin
                            acc  <= '0;
                            sh   <= bus.req_b;
                            opnd <= bus.req_a;
                        end else if (req_div0) begin
                            // Divide by zero resolves immediately: quo all-ones, rem = dividend
                            acc  <= bus.req_a;
                            sh   <= '1;
                            opnd <= bus.req_b;
                        end else begin
                            acc  <= '0;
                            sh   <= bus.req_a;
                            opnd <= bus.req_b;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (is_mul) begin
                        acc <= {c, sum[XLEN-1:1]};
                        sh  <= {sum[0], sh[XLEN-1:1]};
                    end else begin
                        acc <= ge ? alu_result : rs;
                        sh  <= {sh[XLEN-2:0], ge};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a behavioural model of the shared ALU.
module tb_alu_muldiv_seq;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    alu_muldiv_seq_if bus();

    alu_muldiv_seq #(.XLEN(32), .STEPS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parent-side ALU: only ADD and SUB matter here
    always_comb begin
        case (alu_op)
            4'h1:    alu_result = alu_a + alu_b;
            4'h2:    alu_result = alu_a - alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called #1 after a rising edge; returns #1 after the accept edge
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: req_ready=%b required 1", bus.req_ready);
        end
        sb.push_back(ref_res(op, a, b));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Waits (bounded) for resp_valid; counts CALC cycles and ALU opcodes seen
    task automatic wait_resp(output logic [31:0] d, output int lat, output int n_add, output int n_sub);
        lat = 0; n_add = 0; n_sub = 0;
        while (bus.resp_valid !== 1'b1 && lat < 64) begin
            if (alu_op == 4'h1) n_add++;
            if (alu_op == 4'h2) n_sub++;
            @(posedge clk); #1;
            lat++;
        end
        d = bus.resp_data;
    endtask

    task automatic take();
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: ready=%b valid=%b data=%h required 1 0 0", bus.req_ready, bus.resp_valid, bus.resp_data);
        end
        checks++;
        if (alu_op !== 4'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_alu: op=%h a=%h b=%h required 0 0 0", alu_op, alu_a, alu_b);
        end
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_resp_ready: valid=%b ready=%b required 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int exp_lat);
        logic [31:0] d, exp;
        int lat, n_add, n_sub;
        send(op, a, b);
        bus.req_op = ~op;
        wait_resp(d, lat, n_add, n_sub);
        exp = sb.pop_front();
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL %s data: got %h required %h", name, d, exp);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if ((op[1] == 1'b0 && n_add !== exp_lat) || (op[1] == 1'b1 && n_sub !== exp_lat) || alu_op !== 4'h0) begin
            errors++;
            $display("FAIL %s alu_op: add=%0d sub=%0d done_op=%h required %0d calc cycles then 0", name, n_add, n_sub, alu_op, exp_lat);
        end
        take();
    endtask

    task automatic test_mul();
        run_one("mulu_7x6",   2'd0, 32'd7, 32'd6, 32);
        run_one("mulhu_max",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        run_one("mulu_max",   2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        run_one("mulhu_mix",  2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32);
    endtask

    task automatic test_div();
        run_one("divu_100_7", 2'd2, 32'd100, 32'd7, 32);
        run_one("remu_100_7", 2'd3, 32'd100, 32'd7, 32);
        run_one("divu_max_1", 2'd2, 32'hFFFF_FFFF, 32'd1, 32);
        run_one("remu_big",   2'd3, 32'hFFFF_FFFE, 32'h8000_0001, 32);
    endtask

    task automatic test_div_zero();
        run_one("divu_by0", 2'd2, 32'd5, 32'd0, 0);
        run_one("remu_by0", 2'd3, 32'd5, 32'd0, 0);
    endtask

    task automatic test_backpressure();
        logic [31:0] d, exp;
        int lat, n_add, n_sub, bad;
        send(2'd2, 32'd1000, 32'd3);
        wait_resp(d, lat, n_add, n_sub);
        exp = sb.pop_front();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_a     = 32'd9;
        bus.req_b     = 32'd9;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.resp_data !== exp || bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 0 || bus.resp_data !== exp) begin
            errors++;
            $display("FAIL backpressure_hold: bad_cycles=%0d data=%h required 0 %h", bad, bus.resp_data, exp);
        end
        bus.req_valid = 1'b0;
        take();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_ignored_req: valid=%b ready=%b required 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] dropped;
        send(2'd0, 32'd123, 32'd456);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dropped = sb.pop_front();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || alu_op !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b alu_op=%h required 1 0 0 (dropped %h)", bus.req_ready, bus.resp_valid, alu_op, dropped);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_resp: valid=%b required 0", bus.resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, exp, a, b;
        logic [1:0]  op;
        int lat, n_add, n_sub;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 3) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            send(op, a, b);
            wait_resp(d, lat, n_add, n_sub);
            exp = sb.pop_front();
            checks++;
            if (d !== exp) begin
                errors++;
                $display("FAIL b2b_%0d op=%0d a=%h b=%h: got %h required %h", i, op, a, b, d, exp);
            end
            take();
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_a      = 32'h0;
        bus.req_b      = 32'h0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
